strategy_sequencer: RTL and testbench

Programmable scheduler that drives the `strategy_sel` input of the strategy multiplexer. It holds a small table of {strategy, dwell} entries and steps through them on command, optionally looping. Every strategy change is framed by a guard interval with `blank` asserted, so downstream logic can mask transients while the mux output switches. It sits between the control/register interface and the strategy multiplexer, in the same clock domain.

---
 rtl/types_pkg.sv | 27 ++
 rtl/strategy_sched_table.sv | 26 ++
 rtl/strategy_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_strategy_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the strategy multiplexer and its schedule sequencer.
package types_pkg;

  // Strategy codes understood by the multiplexer; NOP passes data through.
  typedef enum logic [7:0] {
    NOP = 8'd0,
    XOR = 8'd1,
    INV = 8'd2
  } strategy_e;

  localparam int NUM_STRATEGIES = 3;

  // Widest dwell a table entry can hold; the sequencer's DWELL_W must not exceed it.
  localparam int SCHED_DWELL_W = 16;

  typedef struct packed {
    logic [7:0]               sel;
    logic [SCHED_DWELL_W-1:0] dwell;
  } sched_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/strategy_sched_table.sv
// Schedule table: DEPTH entries of {strategy, dwell}, no reset, one async read port.
module strategy_sched_table import types_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          running,
  input  logic [AW-1:0] wr_addr,
  input  sched_entry_t  wr_data,
  input  logic [AW-1:0] rd_idx,
  output sched_entry_t  rd_data
);

  sched_entry_t mem [DEPTH];

  // Writes land only while the sequencer is idle so a schedule never sees a torn table.
  always_ff @(posedge clock) begin
    if (we && !running) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/strategy_sequencer.sv
// Steps through a {strategy, dwell} table, blanking around every strategy change.
module strategy_sequencer #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16,
  parameter int GUARD   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [7:0]               cfg_sel,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [7:0]               strategy_sel,
  output logic                     blank,
  output logic                     running,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     wrap,
  output logic                     done,
  output logic                     err
);
  import types_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // The shared down-counter holds "cycles left minus one" for both guard and run.
  localparam int GUARD_M1_I = (GUARD > 0) ? GUARD - 1 : 0;
  localparam logic [DWELL_W-1:0] GUARD_M1 = DWELL_W'(GUARD_M1_I);

  seq_state_e         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]      len_q, len_d;
  logic               loop_q, loop_d;
  logic [7:0]         sel_d;
  logic               blank_d, wrap_d, done_d, err_d;
  logic [AW-1:0]      idx_d;

  sched_entry_t       wr_entry, rd_entry;
  logic [AW-1:0]      rd_addr, next_idx;
  logic               last, code_ok, skip, do_load;
  logic [7:0]         load_sel;
  logic [DWELL_W-1:0] load_dwell, run_m1;

  assign wr_entry = '{sel: cfg_sel, dwell: SCHED_DWELL_W'(cfg_dwell)};

  strategy_sched_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .clock   (clock),
    .we      (cfg_we),
    .running (running),
    .wr_addr (cfg_addr),
    .wr_data (wr_entry),
    .rd_idx  (rd_addr),
    .rd_data (rd_entry)
  );

  // Read the entry about to be loaded (or, in GUARD, the current one for its dwell).
  always_comb begin
    last     = (({1'b0, idx} + 1'b1) == len_q);
    next_idx = last ? '0 : idx + 1'b1;
    case (state_q)
      IDLE:             rd_addr = '0;
      types_pkg::GUARD: rd_addr = idx;
      default:          rd_addr = next_idx;
    endcase
    code_ok    = (rd_entry.sel < 8'(NUM_STRATEGIES));
    load_sel   = code_ok ? rd_entry.sel : 8'(NOP);
    load_dwell = DWELL_W'(rd_entry.dwell);
    run_m1     = (load_dwell == '0) ? '0 : load_dwell - 1'b1;
    // Blanking is pointless when the mux output does not actually change.
    skip       = (GUARD == 0) || (load_sel == strategy_sel);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    loop_d  = loop_q;
    sel_d   = strategy_sel;
    blank_d = blank;
    idx_d   = idx;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = cfg_we && running;
    do_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((len != '0) && (len <= LW'(DEPTH))) begin
            len_d   = len;
            loop_d  = loop;
            idx_d   = '0;
            do_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      types_pkg::GUARD: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          blank_d = 1'b0;
          cnt_d   = run_m1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (!last) begin
            idx_d   = next_idx;
            do_load = 1'b1;
          end else if (loop_q) begin
            wrap_d  = 1'b1;
            idx_d   = '0;
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            sel_d   = 8'(NOP);
            blank_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      sel_d = load_sel;
      if (!code_ok) err_d = 1'b1;
      if (skip) begin
        state_d = RUN;
        blank_d = 1'b0;
        cnt_d   = run_m1;
      end else begin
        state_d = types_pkg::GUARD;
        blank_d = 1'b1;
        cnt_d   = GUARD_M1;
      end
    end

    // Abort overrides everything except reporting a dropped table write.
    if (stop) begin
      state_d = IDLE;
      sel_d   = 8'(NOP);
      blank_d = 1'b0;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = cfg_we && running;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      strategy_sel <= 8'(NOP);
      blank        <= 1'b0;
      running      <= 1'b0;
      idx          <= '0;
      wrap         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      loop_q       <= loop_d;
      strategy_sel <= sel_d;
      blank        <= blank_d;
      running      <= (state_d != IDLE);
      idx          <= idx_d;
      wrap         <= wrap_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_strategy_sequencer.sv
// Scoreboard bench for strategy_sequencer: expected per-cycle outputs are queued at start.
module tb_strategy_sequencer;

  localparam int DEPTH   = 8;
  localparam int DWELL_W = 16;
  localparam int G       = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [7:0]   cfg_sel;
  logic [15:0]  cfg_dwell;
  logic [3:0]   len;
  logic         loop;
  logic         start;
  logic         stop;
  logic [7:0]   strategy_sel;
  logic         blank;
  logic         running;
  logic [2:0]   idx;
  logic         wrap;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;
  string scen = "none";

  // Bench's own copy of what it has written into the table.
  logic [7:0]  tb_sel   [DEPTH];
  logic [15:0] tb_dwell [DEPTH];

  // Expected outputs, one per cycle: {sel, blank, running, idx, wrap, done, err}.
  logic [15:0] sb_q [$];

  strategy_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .GUARD(G)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_sel      (cfg_sel),
    .cfg_dwell    (cfg_dwell),
    .len          (len),
    .loop         (loop),
    .start        (start),
    .stop         (stop),
    .strategy_sel (strategy_sel),
    .blank        (blank),
    .running      (running),
    .idx          (idx),
    .wrap         (wrap),
    .done         (done),
    .err          (err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [7:0] s, input logic b, input logic r,
                                     input logic [2:0] i, input logic w, input logic d,
                                     input logic e);
    return {s, b, r, i, w, d, e};
  endfunction

  function automatic logic [15:0] obs();
    return pk(strategy_sel, blank, running, idx, wrap, done, err);
  endfunction

  // Expand a schedule straight from the rules: guard cycles on a code change, then max(dwell,1).
  function automatic void push_sched(input int n, input bit lp, input int rounds);
    logic [7:0] cur;
    logic [7:0] code;
    int d;
    bit first, w, e;
    cur = 8'd0;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < n; k++) begin
        code  = (tb_sel[k] < 8'd3) ? tb_sel[k] : 8'd0;
        e     = (tb_sel[k] >= 8'd3);
        w     = (r > 0) && (k == 0);
        first = 1'b1;
        if (code != cur) begin
          for (int g = 0; g < G; g++) begin
            sb_q.push_back(pk(code, 1'b1, 1'b1, 3'(k), first & w, 1'b0, first & e));
            first = 1'b0;
          end
        end
        d = (tb_dwell[k] == 16'd0) ? 1 : int'(tb_dwell[k]);
        for (int c = 0; c < d; c++) begin
          sb_q.push_back(pk(code, 1'b0, 1'b1, 3'(k), first & w, 1'b0, first & e));
          first = 1'b0;
        end
        cur = code;
      end
    end
    if (!lp) sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
  endfunction

  // Compare n queued cycles against the DUT, sampling 1ns after each rising edge.
  task automatic drain_n(input int n);
    logic [15:0] e, o;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      stop   = 1'b0;
      e = sb_q.pop_front();
      o = obs();
      if (!e[6]) o[5:3] = 3'd0;
      chk($sformatf("%s[%0d]", scen, i), 32'(o), 32'(e));
    end
  endtask

  task automatic drain();
    drain_n(sb_q.size());
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] s, input logic [15:0] d);
    @(negedge clock);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_sel   = s;
    cfg_dwell = d;
    tb_sel[a]   = s;
    tb_dwell[a] = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic fire_start(input logic [3:0] l, input logic lp);
    start = 1'b1;
    len   = l;
    loop  = lp;
  endtask

  initial begin
    reset = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_dwell = '0;
    len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset", 32'(obs()), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Two entries, guard on each change, single pass.
    scen = "single";
    wr(3'd0, 8'd1, 16'd3);
    wr(3'd1, 8'd2, 16'd2);
    fire_start(4'd2, 1'b0);
    push_sched(2, 1'b0, 1);
    sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drain();

    // Looping schedule, then abort in the middle of RUN (start held too, must lose).
    scen = "loop";
    @(negedge clock);
    fire_start(4'd2, 1'b1);
    push_sched(2, 1'b1, 3);
    while (sb_q.size() > 21) void'(sb_q.pop_back());
    drain();
    stop  = 1'b1;
    start = 1'b1;
    len   = 4'd2;
    sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    scen = "stop";
    drain();

    // Same code twice: no blanking at the second entry.
    scen = "same_code";
    wr(3'd0, 8'd1, 16'd2);
    wr(3'd1, 8'd1, 16'd4);
    fire_start(4'd2, 1'b0);
    push_sched(2, 1'b0, 1);
    drain();

    // Invalid code becomes NOP with err; zero dwell runs one cycle.
    scen = "bad_code";
    wr(3'd0, 8'd7, 16'd5);
    wr(3'd1, 8'd2, 16'd0);
    fire_start(4'd2, 1'b0);
    push_sched(2, 1'b0, 1);
    drain();

    // Table write while running is dropped with err; the rerun shows the old entry.
    scen = "we_running";
    wr(3'd0, 8'd1, 16'd3);
    wr(3'd1, 8'd2, 16'd2);
    fire_start(4'd2, 1'b0);
    push_sched(2, 1'b0, 1);
    drain_n(3);
    cfg_we    = 1'b1;
    cfg_addr  = 3'd0;
    cfg_sel   = 8'd2;
    cfg_dwell = 16'd9;
    sb_q[0][0] = 1'b1;
    drain();
    scen = "readback";
    @(negedge clock);
    fire_start(4'd1, 1'b0);
    push_sched(1, 1'b0, 1);
    drain();

    // Illegal lengths stay idle and flag err.
    scen = "len0";
    @(negedge clock);
    fire_start(4'd0, 1'b0);
    sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drain();
    scen = "len9";
    fire_start(4'd9, 1'b0);
    sb_q.push_back(pk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    drain();

    // Asynchronous reset during GUARD, then a clean rerun of the first schedule.
    scen = "pre_rst";
    @(negedge clock);
    fire_start(4'd2, 1'b0);
    push_sched(2, 1'b0, 1);
    drain_n(1);
    sb_q.delete();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", 32'(obs()), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    scen = "after_rst";
    fire_start(4'd2, 1'b0);
    push_sched(2, 1'b0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
